// File: rtl/gsim_residual_check_if.sv
// Bundle between the Gauss-Seidel solver stage and its residual checker:
// b frame capture, solution word capture, and the result outputs.
interface gsim_residual_check_if;
    logic        in_en;
    logic [15:0] b_in;
    logic        x_valid;
    logic [31:0] x_in;
    logic        done;
    logic        pass;
    logic [31:0] max_err;
    logic [3:0]  err_row;

    // Producer side: drives frames in, observes the verdict.
    modport master (
        output in_en, b_in, x_valid, x_in,
        input  done, pass, max_err, err_row
    );

    // Checker side.
    modport slave (
        input  in_en, b_in, x_valid, x_in,
        output done, pass, max_err, err_row
    );
endinterface

// File: rtl/gsim_residual_check.sv
// Residual checker for the 16x16 banded Gauss-Seidel system.
// Captures b (integers) and x (Q16.16), then evaluates r = b - A*x one row per
// cycle and reports the worst |r|, its row, and a pass/fail verdict against TOL.
module gsim_residual_check #(
    parameter int          N   = 16,
    parameter logic [31:0] TOL = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  reset,
    gsim_residual_check_if.slave  bus
);

    localparam logic [3:0] LAST = 4'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_B = 3'd1,
        S_WAIT_X = 3'd2,
        S_LOAD_X = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  b_q [16];
    logic [15:0]  b_d [16];
    logic [31:0]  x_q [16];
    logic [31:0]  x_d [16];
    logic [31:0]  run_max_q, run_max_d;
    logic [3:0]   run_row_q, run_row_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic [31:0]  max_err_q, max_err_d;
    logic [3:0]   err_row_q, err_row_d;

    // Residual datapath signals for the row selected by cnt_q.
    logic signed [39:0] xc_s, s1_s, s2_s, s3_s;
    logic signed [39:0] ax_s, bsh_s, r_s, abs_s;
    logic [31:0]        mag_s;
    logic [31:0]        new_max_s;
    logic [3:0]         new_row_s;

    // Sign-extend a Q16.16 word into the 40-bit accumulator domain.
    function automatic logic signed [39:0] sx(input logic [31:0] v);
        sx = {{8{v[31]}}, v};
    endfunction

    // Saturate a non-negative 40-bit magnitude to the 31-bit positive range.
    function automatic logic [31:0] sat31(input logic signed [39:0] v);
        if (|v[39:31]) begin
            sat31 = 32'h7FFF_FFFF;
        end else begin
            sat31 = v[31:0];
        end
    endfunction

    // Banded row product and residual magnitude; missing neighbours read as zero.
    always_comb begin
        xc_s  = sx(x_q[cnt_q]);
        s1_s  = 40'sd0;
        s2_s  = 40'sd0;
        s3_s  = 40'sd0;
        if (cnt_q >= 4'd1)  s1_s = s1_s + sx(x_q[cnt_q - 4'd1]); else s1_s = s1_s;
        if (cnt_q <= 4'd14) s1_s = s1_s + sx(x_q[cnt_q + 4'd1]); else s1_s = s1_s;
        if (cnt_q >= 4'd2)  s2_s = s2_s + sx(x_q[cnt_q - 4'd2]); else s2_s = s2_s;
        if (cnt_q <= 4'd13) s2_s = s2_s + sx(x_q[cnt_q + 4'd2]); else s2_s = s2_s;
        if (cnt_q >= 4'd3)  s3_s = s3_s + sx(x_q[cnt_q - 4'd3]); else s3_s = s3_s;
        if (cnt_q <= 4'd12) s3_s = s3_s + sx(x_q[cnt_q + 4'd3]); else s3_s = s3_s;
        // 20x = 16x + 4x; 13s = 8s + 4s + s; 6s = 4s + 2s
        ax_s  = (xc_s <<< 4) + (xc_s <<< 2)
              + (s1_s <<< 3) + (s1_s <<< 2) + s1_s
              - ((s2_s <<< 2) + (s2_s <<< 1))
              + s3_s;
        bsh_s = {{8{b_q[cnt_q][15]}}, b_q[cnt_q], 16'h0000};
        r_s   = bsh_s - ax_s;
        if (r_s[39]) begin
            abs_s = -r_s;
        end else begin
            abs_s = r_s;
        end
        mag_s = sat31(abs_s);
        // Strict compare: a tie keeps the earlier (lower) row.
        if (mag_s > run_max_q) begin
            new_max_s = mag_s;
            new_row_s = cnt_q;
        end else begin
            new_max_s = run_max_q;
            new_row_s = run_row_q;
        end
    end

    // Frame sequencing: capture b, capture x, sweep rows, publish result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        x_d       = x_q;
        run_max_d = run_max_q;
        run_row_d = run_row_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        max_err_d = max_err_q;
        err_row_d = err_row_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_en) begin
                    b_d[0]  = bus.b_in;
                    cnt_d   = 4'd1;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d   = 4'd0;
                end
            end
            S_LOAD_B: begin
                if (bus.in_en) begin
                    b_d[cnt_q] = bus.b_in;
                    if (cnt_q == LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_WAIT_X;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    // Short frame: drop it and wait for a fresh one.
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_X, S_LOAD_X: begin
                if (bus.x_valid) begin
                    x_d[cnt_q] = bus.x_in;
                    if (cnt_q == LAST) begin
                        cnt_d     = 4'd0;
                        run_max_d = 32'h0000_0000;
                        run_row_d = 4'd0;
                        state_d   = S_CHECK;
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        state_d   = S_LOAD_X;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CHECK: begin
                run_max_d = new_max_s;
                run_row_d = new_row_s;
                if (cnt_q == LAST) begin
                    cnt_d     = 4'd0;
                    done_d    = 1'b1;
                    pass_d    = (new_max_s <= TOL);
                    max_err_d = new_max_s;
                    err_row_d = new_row_s;
                    state_d   = S_DONE;
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, storage and result registers; reset aborts any frame silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                b_q[i] <= 16'h0000;
                x_q[i] <= 32'h0000_0000;
            end
            run_max_q <= 32'h0000_0000;
            run_row_q <= 4'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            max_err_q <= 32'h0000_0000;
            err_row_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            x_q       <= x_d;
            run_max_q <= run_max_d;
            run_row_q <= run_row_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            max_err_q <= max_err_d;
            err_row_q <= err_row_d;
        end
    end

    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.max_err = max_err_q;
    assign bus.err_row = err_row_q;

endmodule

// File: tb/tb_gsim_residual_check.sv
// Directed bench for gsim_residual_check: table of frames with hand-computed
// residual results, plus abort, gapped-x and reset-during-check sequences.
module tb_gsim_residual_check;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gsim_residual_check_if bus();

    gsim_residual_check #(.N(16), .TOL(32'h0000_1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0][15:0] b;
        logic [15:0][31:0] x;
        logic              gap;
        logic              exp_pass;
        logic [31:0]       exp_max;
        logic [3:0]        exp_row;
    } vec_t;

    localparam int NV = 8;
    // Edges from the x_15 sampling edge until done is visible.
    localparam int EXP_LAT = 16;

    vec_t vecs [NV];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [15:0][15:0] b);
        for (int k = 0; k < 16; k++) begin
            bus.in_en = 1'b1;
            bus.b_in  = b[k];
            step();
        end
        bus.in_en = 1'b0;
        bus.b_in  = 16'h0000;
    endtask

    task automatic send_x(input logic [15:0][31:0] x, input logic gap);
        for (int k = 0; k < 16; k++) begin
            bus.x_valid = 1'b1;
            bus.x_in    = x[k];
            step();
            bus.x_valid = 1'b0;
            bus.x_in    = 32'h0000_0000;
            if (gap && k != 15) step();
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        send_b(v.b);
        send_x(v.x, v.gap);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(EXP_LAT));
        check({name, "_pass"}, {31'd0, bus.pass}, {31'd0, v.exp_pass});
        check({name, "_max_err"}, bus.max_err, v.exp_max);
        check({name, "_err_row"}, {28'd0, bus.err_row}, {28'd0, v.exp_row});
        step();
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int   ndone;
        vec_t g;

        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // 0: all zero
        vecs[0].exp_pass = 1'b1;
        // 1: b equals column 0 of A, x_0 = 1.0 -> exact solution
        vecs[1].b[0] = 16'd20; vecs[1].b[1] = 16'd13; vecs[1].b[2] = 16'hFFFA; vecs[1].b[3] = 16'd1;
        vecs[1].x[0] = 32'h0001_0000;
        vecs[1].exp_pass = 1'b1;
        // 2: perturb x_5 by 1/256 -> r_5 = -5120
        vecs[2] = vecs[1];
        vecs[2].x[5] = 32'h0000_0100;
        vecs[2].exp_pass = 1'b0; vecs[2].exp_max = 32'h0000_1400; vecs[2].exp_row = 4'd5;
        // 3: saturation, rows 0..3 all saturate, lowest row wins
        vecs[3].b[0] = 16'h7FFF; vecs[3].x[0] = 32'h8000_0000;
        vecs[3].exp_pass = 1'b0; vecs[3].exp_max = 32'h7FFF_FFFF; vecs[3].exp_row = 4'd0;
        // 4: tie between rows 3 and 9 -> row 3
        vecs[4].b[3] = 16'd1; vecs[4].b[9] = 16'd1;
        vecs[4].exp_pass = 1'b0; vecs[4].exp_max = 32'h0001_0000; vecs[4].exp_row = 4'd3;
        // 5: last row dominates: r_15 = -20*16
        vecs[5].x[15] = 32'h0000_0010;
        vecs[5].exp_pass = 1'b1; vecs[5].exp_max = 32'h0000_0140; vecs[5].exp_row = 4'd15;
        // 6: |r_0| = 20*197 + 13*12 = 4096 exactly at TOL
        vecs[6].x[0] = 32'h0000_00C5; vecs[6].x[1] = 32'h0000_000C;
        vecs[6].exp_pass = 1'b1; vecs[6].exp_max = 32'h0000_1000; vecs[6].exp_row = 4'd0;
        // 7: one LSB above TOL via x_3 (A[0][3] = 1)
        vecs[7] = vecs[6];
        vecs[7].x[3] = 32'h0000_0001;
        vecs[7].exp_pass = 1'b0; vecs[7].exp_max = 32'h0000_1001; vecs[7].exp_row = 4'd0;

        reset       = 1'b1;
        bus.in_en   = 1'b0;
        bus.b_in    = 16'h0000;
        bus.x_valid = 1'b0;
        bus.x_in    = 32'h0000_0000;
        step();
        step();
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_pass", {31'd0, bus.pass}, 32'd0);
        check("rst_max_err", bus.max_err, 32'd0);
        check("rst_err_row", {28'd0, bus.err_row}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Short b frame then stray x words: nothing may happen.
        for (int k = 0; k < 5; k++) begin
            bus.in_en = 1'b1;
            bus.b_in  = 16'h0011;
            step();
        end
        bus.in_en = 1'b0;
        step();
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            bus.x_valid = 1'b1;
            bus.x_in    = 32'h1234_5678;
            step();
            if (bus.done) ndone++;
        end
        bus.x_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_pass_held", {31'd0, bus.pass}, {31'd0, vecs[NV-1].exp_pass});
        check("abort_max_held", bus.max_err, vecs[NV-1].exp_max);
        check("abort_row_held", {28'd0, bus.err_row}, {28'd0, vecs[NV-1].exp_row});

        // Valid frame with one idle cycle between x words.
        g     = vecs[2];
        g.gap = 1'b1;
        run_vec(g, "gapped");

        // Reset in the middle of the row sweep.
        send_b(vecs[0].b);
        send_x(vecs[0].x, 1'b0);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_pass", {31'd0, bus.pass}, 32'd0);
        check("midrst_max_err", bus.max_err, 32'd0);
        check("midrst_err_row", {28'd0, bus.err_row}, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_vec(vecs[0], "post_rst_zero");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
